// File: rtl/rv_backup_ctrl_if.sv
// NVM port of the backup controller: single outstanding word transaction,
// completed by a one-cycle ack sampled on the rising clock edge.
interface rv_backup_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/rv_backup_ctrl.sv
// Checkpoint engine: copies dirty core registers to NVM on backup and reloads
// every register slot from NVM on restore, holding the core while busy.
module rv_backup_ctrl #(
  parameter int NUM_REGS = 53,
  parameter int ADDR_W   = 8,
  parameter int NVM_BASE = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     backup_req,
  input  logic                     restore_req,
  input  logic [2*NUM_REGS-1:0]    dirty_vals,
  output logic [NUM_REGS-1:0]      backup_ens,
  input  logic [32*NUM_REGS-1:0]   backup_Vouts,
  output logic [NUM_REGS-1:0]      backup_acks,
  output logic [NUM_REGS-1:0]      restore_ens,
  output logic [32*NUM_REGS-1:0]   restore_Vins,
  rv_backup_ctrl_if.master         nvm,
  output logic                     core_hold,
  output logic                     done,
  output logic [6:0]               saved_cnt
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE,
    B_SCAN,
    B_EN,
    B_WR,
    B_ACK,
    R_RD,
    R_EN,
    DONE
  } state_t;

  state_t      state;
  idx_t        idx;
  logic [31:0] rdata_q;

  logic [NUM_REGS-1:0] dirty;
  logic [NUM_REGS-1:0] odd_flags;
  logic                unused_odd_flags;

  function automatic logic [ADDR_W-1:0] slot_addr(input idx_t i);
    return ADDR_W'(NVM_BASE) + ADDR_W'(i);
  endfunction

  // Split the per-register flag pairs: only the even bit (dirty) matters here.
  always_comb begin
    dirty     = '0;
    odd_flags = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      dirty[i]     = dirty_vals[2*i];
      odd_flags[i] = dirty_vals[2*i+1];
    end
  end

  // The odd flag bits belong to the core's own bookkeeping.
  always_comb unused_odd_flags = ^odd_flags;

  // Restore data is broadcast to every register; only the enabled one loads.
  always_comb restore_Vins = {NUM_REGS{rdata_q}};

  // Sequencer. Outputs are registered on the transition into the state in
  // which they are asserted, so each strobe lines up exactly with its state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      idx         <= '0;
      backup_ens  <= '0;
      backup_acks <= '0;
      restore_ens <= '0;
      nvm.req     <= 1'b0;
      nvm.we      <= 1'b0;
      nvm.addr    <= '0;
      nvm.wdata   <= '0;
      rdata_q     <= '0;
      core_hold   <= 1'b0;
      done        <= 1'b0;
      saved_cnt   <= '0;
    end else begin
      backup_ens  <= '0;
      backup_acks <= '0;
      restore_ens <= '0;
      done        <= 1'b0;

      unique case (state)
        IDLE: begin
          if (backup_req) begin
            idx       <= '0;
            saved_cnt <= '0;
            core_hold <= 1'b1;
            state     <= B_SCAN;
          end else if (restore_req) begin
            idx       <= '0;
            core_hold <= 1'b1;
            nvm.req   <= 1'b1;
            nvm.we    <= 1'b0;
            nvm.addr  <= slot_addr('0);
            state     <= R_RD;
          end
        end

        B_SCAN: begin
          if (idx == IDX_W'(NUM_REGS)) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (!dirty[idx]) begin
            idx <= idx + IDX_W'(1);
          end else begin
            backup_ens[idx] <= 1'b1;
            state           <= B_EN;
          end
        end

        B_EN: begin
          nvm.wdata <= backup_Vouts[32*idx +: 32];
          nvm.req   <= 1'b1;
          nvm.we    <= 1'b1;
          nvm.addr  <= slot_addr(idx);
          state     <= B_WR;
        end

        B_WR: begin
          if (nvm.ack) begin
            nvm.req          <= 1'b0;
            nvm.we           <= 1'b0;
            backup_acks[idx] <= 1'b1;
            state            <= B_ACK;
          end
        end

        B_ACK: begin
          saved_cnt <= saved_cnt + 7'd1;
          idx       <= idx + IDX_W'(1);
          state     <= B_SCAN;
        end

        R_RD: begin
          if (nvm.ack) begin
            rdata_q          <= nvm.rdata;
            nvm.req          <= 1'b0;
            restore_ens[idx] <= 1'b1;
            state            <= R_EN;
          end
        end

        R_EN: begin
          if (idx == IDX_W'(NUM_REGS - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= idx + IDX_W'(1);
            nvm.req  <= 1'b1;
            nvm.we   <= 1'b0;
            nvm.addr <= slot_addr(idx + IDX_W'(1));
            state    <= R_RD;
          end
        end

        DONE: begin
          core_hold <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
